// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative shift-add multiplier (mul_seq).
//   MUL_WIDTH   : default operand width; the product is 2*MUL_WIDTH bits
//   MUL_CNT_W   : width of the step counter for the default operand width
//   mul_state_t : control FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// -----------------------------------------------------------------------------
// mul_seq_if
// Operand/result bundle between the ALU and the sequential multiplier.
//   start     : request a multiply (ALU -> multiplier)
//   mul1      : multiplicand magnitude, WIDTH bits
//   mul2      : multiplier magnitude, WIDTH bits
//   busy      : multiply in progress
//   done      : one-cycle pulse, mulresult valid
//   mulresult : 2*WIDTH-bit unsigned product
// Modports: master = ALU side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface mul_seq_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
);

    logic                   start;
    logic [WIDTH-1:0]       mul1;
    logic [WIDTH-1:0]       mul2;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     mulresult;

    modport master (
        output start, mul1, mul2,
        input  busy, done, mulresult
    );

    modport slave (
        input  start, mul1, mul2,
        output busy, done, mulresult
    );

endinterface

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Iterative WIDTH x WIDTH unsigned shift-add multiplier. One partial product
// is accumulated per RUN cycle; the 2*WIDTH-bit product is published on the
// done pulse and held until the next accepted start.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (priority over start)
//   bus    : mul_seq_if.slave (start, mul1, mul2 in; busy, done, mulresult out)
//
// Build option:
//   MUL_SEQ_EARLY_EXIT_EN - when defined, RUN ends as soon as the remaining
//   multiplier bits are all zero; otherwise latency is fixed at WIDTH+1 edges.
// -----------------------------------------------------------------------------
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    mul_seq_if.slave   bus
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      result_q;

    logic [PW-1:0]      acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               last_d;

    // One shift-add step; the accumulator never overflows since the final
    // product of two WIDTH-bit magnitudes fits in 2*WIDTH bits.
    always_comb begin
        acc_d    = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        last_d   = (cnt_q == CNT_LAST);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        // No set bits left: remaining steps would add nothing.
        last_d   = last_d || (mplier_d == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                // DONE shares IDLE's accept path so back-to-back starts
                // lose no cycle.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_q  <= PW'(bus.mul1);
                        mplier_q <= bus.mul2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end

                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        result_q <= acc_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mulresult = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Self-checking bench for mul_seq. A behavioural model (product via plain
// multiplication, latency via a countdown of the expected step count) is
// compared against the DUT outputs on every falling edge; directed tests pin
// the model with hand-computed products and latencies.
// Honours MUL_SEQ_EARLY_EXIT_EN for the expected latencies.
// -----------------------------------------------------------------------------
module tb_mul_seq;

    import mul_pkg::*;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    mul_seq_if #(.WIDTH(16)) bus ();

    mul_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Number of RUN cycles the multiplier needs for a given mul2.
    function automatic int unsigned steps_for(input logic [15:0] b);
        int unsigned s;
        if (!EARLY) return 16;
        s = 1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) s = i + 1;
        end
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    int unsigned  m_rem = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [31:0]  m_res  = '0;
    logic [31:0]  m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_rem == 0 && bus.start) begin
            m_pend <= {16'h0, bus.mul1} * {16'h0, bus.mul2};
            m_rem  <= steps_for(bus.mul2);
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("mulresult", 64'(bus.mulresult), 64'(m_res));
            chk("busy_done_excl", 64'(bus.busy & bus.done), 64'(0));
        end
    end

    // Pulse start for one cycle, then measure edges (acceptance edge = 1)
    // until done is seen.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p, input int exp_edges);
        int n;
        @(negedge clk);
        bus.mul1  = a;
        bus.mul2  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(exp_edges));
        chk({nm, "_result"}, 64'(bus.mulresult), 64'(exp_p));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int extra;

        bus.start = 1'b0;
        bus.mul1  = '0;
        bus.mul2  = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_result", 64'(bus.mulresult), 64'(0));
        chk_en = 1'b1;
        reset  = 1'b0;

        // Basic and boundary products
        run_op("basic_3x5", 16'd3, 16'd5, 32'h0000_000F, EARLY ? 4 : 17);
        run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17);
        run_op("8000x2", 16'h8000, 16'h0002, 32'h0001_0000, EARLY ? 3 : 17);
        run_op("ff_x1", 16'h00FF, 16'h0001, 32'h0000_00FF, EARLY ? 2 : 17);
        run_op("5_x0", 16'd5, 16'd0, 32'h0, EARLY ? 2 : 17);
        run_op("1_x8000", 16'd1, 16'h8000, 32'h0000_8000, 17);

        // Start during RUN is ignored; operand changes have no effect
        @(negedge clk);
        bus.mul1 = 16'd100; bus.mul2 = 16'd200; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 1;
        repeat (5) begin @(posedge clk); #1; n++; end
        bus.start = 1'b1; bus.mul1 = 16'hFFFF; bus.mul2 = 16'h1234;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n++;
        bus.mul1 = 16'hAAAA; bus.mul2 = 16'h5555;
        while (!bus.done && n < 60) begin @(posedge clk); #1; n++; end
        chk("ignored_latency", 64'(n), 64'(EARLY ? 9 : 17));
        chk("ignored_result", 64'(bus.mulresult), 64'(20000));
        extra = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.done) extra++; end
        chk("ignored_no_second_done", 64'(extra), 64'(0));

        // Back-to-back with start held
        @(negedge clk);
        bus.mul1 = 16'd7; bus.mul2 = 16'd9; bus.start = 1'b1;
        @(posedge clk);
        #1 n = 1;
        while (!bus.done && n < 60) begin @(posedge clk); #1; n++; end
        chk("b2b_first_latency", 64'(n), 64'(EARLY ? 5 : 17));
        chk("b2b_first_result", 64'(bus.mulresult), 64'h3F);
        bus.mul1 = 16'h1234; bus.mul2 = 16'h0010;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.done && n < 60);
        bus.start = 1'b0;
        chk("b2b_gap", 64'(n), 64'(EARLY ? 6 : 17));
        chk("b2b_second_result", 64'(bus.mulresult), 64'h12340);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.mul1 = 16'hFFFF; bus.mul2 = 16'hFFFF; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrun_busy", 64'(bus.busy), 64'(1));
        chk("midrun_result_held", 64'(bus.mulresult), 64'h12340);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midreset_busy", 64'(bus.busy), 64'(0));
        chk("midreset_done", 64'(bus.done), 64'(0));
        chk("midreset_result", 64'(bus.mulresult), 64'(0));
        run_op("after_reset_2x2", 16'd2, 16'd2, 32'd4, EARLY ? 3 : 17);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 150) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       bus.mul1 = 16'hFFFF;
                1:       bus.mul1 = 16'h0000;
                default: bus.mul1 = 16'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0:       bus.mul2 = 16'hFFFF;
                1:       bus.mul2 = 16'h0000;
                2:       bus.mul2 = 16'(1 << $urandom_range(0, 15));
                3:       bus.mul2 = 16'($urandom_range(0, 255));
                default: bus.mul2 = 16'($urandom);
            endcase
        end
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative 16x16 unsigned shift-add multiplier that sits directly downstream of the ALU's multiply operand outputs and feeds the 32-bit product back to the ALU's `mulresult` input. The ALU has already converted both operands to magnitudes and applies the sign correction itself, so this block is purely unsigned. The control state machine launches a multiply with `start` and asserts the ALU's second-execute phase once `done` is seen.

## Interface
Parameters:
- `WIDTH`, default 16: operand width. The product is 2*WIDTH bits.

Ports:
- `clk`, input, 1: system clock; all state is updated on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE or DONE.
- `mul1`, input, WIDTH: multiplicand (unsigned magnitude from the ALU).
- `mul2`, input, WIDTH: multiplier (unsigned magnitude from the ALU).
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when `mulresult` becomes valid.
- `mulresult`, output, 2*WIDTH: product. Holds its value until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**: on `start`, latch `mul1` into the multiplicand register (zero-extended to 2*WIDTH) and `mul2` into the multiplier shift register. Clear the accumulator, clear the bit counter, then go to RUN.
- **RUN**: each cycle, if multiplier bit 0 is 1, add the multiplicand to the accumulator (2*WIDTH-bit add; it cannot overflow). Shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter. When the counter reaches WIDTH-1 on this cycle, go to DONE and load the final accumulator value into `mulresult`.
- **DONE**: `done`=1 for exactly this one cycle.
  - With `start`=1: accept new operands immediately and go to RUN (back-to-back operation).
  - Otherwise: go to IDLE.
- `start` in RUN is ignored; it is not queued.
- `mul1`/`mul2` are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- `mulresult` is not updated during RUN. It shows the previous product until DONE.
- **Reset**, at any time including mid-RUN:
  - state goes to IDLE;
  - `busy`=0, `done`=0, `mulresult`=0, accumulator and counter are 0;
  - the in-flight operation is discarded.
- Reset has priority over `start` in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `mulresult`=0.
- Latency: `start` is accepted at edge E0. `busy`=1 for the cycles following edges E0 through E(WIDTH-1). `done`=1 and `mulresult` are valid in the cycle following edge E(WIDTH). For WIDTH=16 that is 16 RUN cycles, and `done` appears 17 edges after acceptance.
- Throughput with back-to-back `start`: one product per WIDTH+1 cycles.
- `done` and `busy` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `MUL_SEQ_EARLY_EXIT_EN`.
- **Defined**: RUN also ends early when the remaining multiplier shift register is zero after the current step. DONE follows on the next edge with the same product.
  - Latency = (index of the highest set bit of `mul2`) + 2 edges, minimum 2.
  - `mul2`=0 gives `done` 2 edges after acceptance, with `mulresult`=0.
- **Undefined**: fixed latency of WIDTH+1 edges for every operand pair.

## Structure
- Shared package `mul_pkg`:
  - state enum `mul_state_t` (IDLE, RUN, DONE);
  - constant `MUL_WIDTH`=16;
  - counter width `$clog2(MUL_WIDTH)`.
- No sub-module. The block is a single FSM plus datapath (accumulator, two shift registers, counter). The ALU instantiates nothing; the top level wires `mul1`, `mul2` and `mulresult` between the two blocks.

## Test plan
- **Basic product**: `mul1`=3, `mul2`=5, pulse `start` → `busy` for 16 cycles, then `done`=1 with `mulresult`=0x0000000F. `done` appears 17 edges after acceptance (fixed-latency build).
- **Maximum operands**: `mul1`=0xFFFF, `mul2`=0xFFFF → `mulresult`=0xFFFE0001. Also check 0x8000*0x0002 → 0x00010000.
- **Ignored start and operand stability**: assert `start` with different operands at RUN cycle 5, and change `mul1`/`mul2` mid-RUN → result equals the originally latched product, and no second `done` follows.
- **Back-to-back**: hold `start` high with 7*9, then 0x1234*0x0010 → `done` pulses 17 edges apart, with `mulresult` 0x3F then 0x12340.
- **Reset mid-operation**: assert `reset` at RUN cycle 8 → next cycle `busy`=0, `done`=0, `mulresult`=0. A following 2*2 multiply returns 4 with normal latency.
- **Early exit** (`MUL_SEQ_EARLY_EXIT_EN` defined):
  - 0x00FF*0x0001 → `done` 2 edges after acceptance, `mulresult`=0xFF;
  - 5*0 → `done` after 2 edges, `mulresult`=0;
  - 1*0x8000 → 17 edges, `mulresult`=0x8000.
